// File: rtl/jtag_ir.sv
// JTAG instruction register: captures, shifts and latches the instruction and decodes DR selects.
// Optional build macro JTAG_IR_CAPTURE_STATUS_EN adds a status input loaded into the upper capture bits.
module jtag_ir #(
  parameter int                     IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0]    OP_EXTEST = 4'b0000,
  parameter logic [IR_WIDTH-1:0]    OP_SAMPLE = 4'b0001,
  parameter logic [IR_WIDTH-1:0]    OP_IDCODE = 4'b0010,
  parameter logic [IR_WIDTH-1:0]    OP_BYPASS = 4'b1111
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                tap_reset,
  input  logic                ir_capture,
  input  logic                ir_shift,
  input  logic                ir_update,
  input  logic                TDI,
`ifdef JTAG_IR_CAPTURE_STATUS_EN
  input  logic [IR_WIDTH-3:0] status,
`endif
  output logic                ir_tdo,
  output logic                ir_tdo_en,
  output logic [IR_WIDTH-1:0] instr,
  output logic                sel_bypass,
  output logic                sel_idcode,
  output logic                sel_bsr,
  output logic                extest_mode
);

  logic [IR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic [IR_WIDTH-1:0] capture_val;

  // The two LSBs of the captured pattern are fixed at 01 so a scan can verify IR continuity.
`ifdef JTAG_IR_CAPTURE_STATUS_EN
  assign capture_val = {status, 2'b01};
`else
  assign capture_val = {{(IR_WIDTH-2){1'b0}}, 2'b01};
`endif

  always_comb begin
    shift_d = shift_q;
    instr_d = instr_q;
    if (tap_reset) begin
      shift_d = '0;
      instr_d = OP_IDCODE;
    end else if (ir_capture) begin
      shift_d = capture_val;
    end else if (ir_shift) begin
      shift_d = {TDI, shift_q[IR_WIDTH-1:1]};
    end else if (ir_update) begin
      instr_d = shift_q;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      shift_q <= '0;
      instr_q <= OP_IDCODE;
    end else begin
      shift_q <= shift_d;
      instr_q <= instr_d;
    end
  end

  assign ir_tdo    = shift_q[0];
  assign ir_tdo_en = ir_shift;
  assign instr     = instr_q;

  // Undefined opcodes fall through to BYPASS so exactly one select is always active.
  always_comb begin
    sel_bypass  = 1'b0;
    sel_idcode  = 1'b0;
    sel_bsr     = 1'b0;
    extest_mode = 1'b0;
    if (instr_q == OP_EXTEST) begin
      sel_bsr     = 1'b1;
      extest_mode = 1'b1;
    end else if (instr_q == OP_SAMPLE) begin
      sel_bsr     = 1'b1;
    end else if (instr_q == OP_IDCODE) begin
      sel_idcode  = 1'b1;
    end else begin
      sel_bypass  = 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_ir.sv
// Directed bench for jtag_ir: vector table for IR scans plus hand sequences for async reset and status capture.
module tb_jtag_ir;

  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic       tap_reset = 1'b0;
  logic       ir_capture = 1'b0;
  logic       ir_shift = 1'b0;
  logic       ir_update = 1'b0;
  logic       TDI = 1'b0;
  logic [1:0] status = 2'b00;
  logic       ir_tdo, ir_tdo_en, sel_bypass, sel_idcode, sel_bsr, extest_mode;
  logic [3:0] instr;

  int tests = 0;
  int fails = 0;

  jtag_ir dut (
    .TCK(TCK), .TRST(TRST), .tap_reset(tap_reset), .ir_capture(ir_capture),
    .ir_shift(ir_shift), .ir_update(ir_update), .TDI(TDI),
`ifdef JTAG_IR_CAPTURE_STATUS_EN
    .status(status),
`endif
    .ir_tdo(ir_tdo), .ir_tdo_en(ir_tdo_en), .instr(instr),
    .sel_bypass(sel_bypass), .sel_idcode(sel_idcode), .sel_bsr(sel_bsr),
    .extest_mode(extest_mode)
  );

  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       trs;
    logic       cap;
    logic       sh;
    logic       upd;
    logic       tdi;
    logic       exp_tdo;
    logic [3:0] exp_instr;
    logic [2:0] exp_sel;   // {bypass, idcode, bsr}
    logic       exp_ext;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic trs, cap, sh, upd, tdi, etdo,
                     input logic [3:0] ei, input logic [2:0] es, input logic ee);
    vec_t v;
    v.trs = trs; v.cap = cap; v.sh = sh; v.upd = upd; v.tdi = tdi;
    v.exp_tdo = etdo; v.exp_instr = ei; v.exp_sel = es; v.exp_ext = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic trs, cap, sh, upd, tdi);
    tap_reset = trs; ir_capture = cap; ir_shift = sh; ir_update = upd; TDI = tdi;
  endtask

  task automatic chk_outs(input string nm, input logic [3:0] ei, input logic [2:0] es, input logic ee);
    chk({nm, "_instr"}, 32'(instr), 32'(ei));
    chk({nm, "_sel"}, 32'({sel_bypass, sel_idcode, sel_bsr}), 32'(es));
    chk({nm, "_extest"}, 32'(extest_mode), 32'(ee));
  endtask

  initial begin
    //   trs cap sh upd tdi | tdo(before edge) instr(after) sel ext
    add(0, 1, 0, 0, 0,  0, 4'b0010, 3'b010, 0); // capture
    add(0, 0, 1, 0, 1,  1, 4'b0010, 3'b010, 0); // shift 1111
    add(0, 0, 1, 0, 1,  0, 4'b0010, 3'b010, 0);
    add(0, 0, 1, 0, 1,  0, 4'b0010, 3'b010, 0);
    add(0, 0, 1, 0, 1,  0, 4'b0010, 3'b010, 0);
    add(0, 0, 0, 1, 0,  1, 4'b1111, 3'b100, 0); // update -> BYPASS
    add(0, 1, 0, 0, 0,  1, 4'b1111, 3'b100, 0); // capture
    add(0, 0, 1, 0, 0,  1, 4'b1111, 3'b100, 0); // shift 0000, selects hold
    add(0, 0, 1, 0, 0,  0, 4'b1111, 3'b100, 0);
    add(0, 0, 1, 0, 0,  0, 4'b1111, 3'b100, 0);
    add(0, 0, 1, 0, 0,  0, 4'b1111, 3'b100, 0);
    add(0, 0, 0, 1, 0,  0, 4'b0000, 3'b001, 1); // update -> EXTEST
    add(0, 1, 0, 0, 0,  0, 4'b0000, 3'b001, 1); // capture
    add(0, 0, 1, 0, 1,  1, 4'b0000, 3'b001, 1); // shift 0101 LSB-first
    add(0, 0, 1, 0, 0,  0, 4'b0000, 3'b001, 1);
    add(0, 0, 1, 0, 1,  0, 4'b0000, 3'b001, 1);
    add(0, 0, 1, 0, 0,  0, 4'b0000, 3'b001, 1);
    add(0, 0, 0, 1, 0,  1, 4'b0101, 3'b100, 0); // undefined -> BYPASS
    add(0, 1, 0, 0, 0,  1, 4'b0101, 3'b100, 0); // capture
    add(0, 0, 0, 1, 0,  1, 4'b0001, 3'b001, 0); // update w/o shift -> SAMPLE
    add(0, 0, 1, 0, 0,  1, 4'b0001, 3'b001, 0); // shift_q -> 0000
    add(1, 0, 0, 1, 0,  0, 4'b0010, 3'b010, 0); // tap_reset beats update
    add(0, 1, 1, 1, 0,  0, 4'b0010, 3'b010, 0); // capture beats shift/update
    add(0, 0, 1, 1, 1,  1, 4'b0010, 3'b010, 0); // shift beats update
    add(0, 0, 0, 1, 0,  0, 4'b1000, 3'b100, 0); // update latches 1000
    add(0, 0, 0, 0, 1,  0, 4'b1000, 3'b100, 0); // idle holds

    // Reset: TRST for two cycles
    TRST = 1'b1;
    repeat (2) @(posedge TCK);
    #1 TRST = 1'b0;
    #1;
    chk_outs("reset", 4'b0010, 3'b010, 1'b0);
    chk("reset_tdo", 32'(ir_tdo), 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].trs, vecs[i].cap, vecs[i].sh, vecs[i].upd, vecs[i].tdi);
      #1;
      chk($sformatf("v%0d_tdo", i), 32'(ir_tdo), 32'(vecs[i].exp_tdo));
      chk($sformatf("v%0d_tdo_en", i), 32'(ir_tdo_en), 32'(vecs[i].sh));
      @(posedge TCK);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].exp_instr, vecs[i].exp_sel, vecs[i].exp_ext);
    end

    // Async TRST mid-shift after loading BYPASS
    drive(0, 1, 0, 0, 0); @(posedge TCK); #1;
    drive(0, 0, 1, 0, 1); repeat (4) @(posedge TCK); #1;
    drive(0, 0, 0, 1, 0); @(posedge TCK); #1;
    chk_outs("pre_trst", 4'b1111, 3'b100, 1'b0);
    drive(0, 1, 0, 0, 0); @(posedge TCK); #1;
    drive(0, 0, 1, 0, 1); @(posedge TCK); #1;
    chk("pre_trst_tdo", 32'(ir_tdo), 32'd0);
    drive(0, 0, 1, 0, 1); @(posedge TCK); #2;
    TRST = 1'b1;
    #1;
    chk_outs("trst_async", 4'b0010, 3'b010, 1'b0);
    chk("trst_async_tdo", 32'(ir_tdo), 32'd0);
    @(posedge TCK); #1;
    TRST = 1'b0;
    drive(0, 0, 0, 1, 0); @(posedge TCK); #1;
    chk_outs("post_trst_update", 4'b0000, 3'b001, 1'b1);
    drive(0, 0, 0, 0, 0); @(posedge TCK); #1;

`ifdef JTAG_IR_CAPTURE_STATUS_EN
    status = 2'b10;
    drive(0, 1, 0, 0, 0); @(posedge TCK); #1;
    begin
      logic [3:0] exp_seq;
      exp_seq = 4'b1001; // ir_tdo order is bit0 first
      for (int k = 0; k < 4; k++) begin
        drive(0, 0, 1, 0, 0);
        #1;
        chk($sformatf("status_tdo%0d", k), 32'(ir_tdo), 32'(exp_seq[k]));
        @(posedge TCK); #1;
      end
    end
    drive(0, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_ir.md
Name: jtag_ir

Overview:
- JTAG instruction register and decoder, directly downstream of the TAP controller.
- Consumes the TAP's IR control strobes (ir_capture, ir_shift, ir_update) and tap_reset.
- Shifts an instruction in from TDI, latches it on update, and drives one-hot data-register selects for the DR chain mux (bypass, IDCODE, boundary scan).
- Also drives the IR's serial TDO contribution.

Parameters:
- IR_WIDTH, 4: instruction length in bits; must be ≥ 2.
- OP_EXTEST, 4'b0000: EXTEST opcode.
- OP_SAMPLE, 4'b0001: SAMPLE/PRELOAD opcode.
- OP_IDCODE, 4'b0010: IDCODE opcode.
- OP_BYPASS, 4'b1111: BYPASS opcode; any undefined opcode also decodes to BYPASS.

Ports:
- TCK, input, 1: JTAG clock; the only clock.
- TRST, input, 1: asynchronous active-high reset.
- tap_reset, input, 1: TAP in Test-Logic-Reset; synchronous.
- ir_capture, input, 1: TAP in Capture-IR.
- ir_shift, input, 1: TAP in Shift-IR.
- ir_update, input, 1: TAP in Update-IR, single-cycle strobe.
- TDI, input, 1: serial data in.
- ir_tdo, output, 1: IR serial out (shift register LSB).
- ir_tdo_en, output, 1: ir_tdo is valid; equals ir_shift.
- instr, output, IR_WIDTH: active (latched) instruction.
- sel_bypass, output, 1: BYPASS register is selected.
- sel_idcode, output, 1: IDCODE register is selected.
- sel_bsr, output, 1: boundary-scan register is selected (EXTEST or SAMPLE).
- extest_mode, output, 1: boundary cells drive pins.

Behaviour:
- Reset is asynchronous and active-high on TRST; TCK is the only clock. No other clock or reset exists.
- Two registers:
  - shift_q: IR_WIDTH bits.
  - instr_q: IR_WIDTH bits.
- Reset values while TRST is high:
  - shift_q = 0.
  - instr_q = OP_IDCODE.
  - Therefore sel_idcode = 1, all other selects = 0, ir_tdo = 0.
- Synchronous update on TCK rising edge. Priority is highest first: tap_reset > ir_capture > ir_shift > ir_update.
  - tap_reset: instr_q ← OP_IDCODE; shift_q ← 0.
  - ir_capture: shift_q ← {(IR_WIDTH-2)'b0, 2'b01}. The LSBs are fixed at 01 per 1149.1.
  - ir_shift: shift_q ← {TDI, shift_q[IR_WIDTH-1:1]}. Shifting is LSB-first out, MSB-in.
  - ir_update: instr_q ← shift_q. shift_q holds its value.
  - None of the above: both registers hold.
- The TAP never asserts more than one of the IR strobes at once. If it does, the priority above resolves it deterministically; the verifier checks this.
- ir_tdo = shift_q[0], combinational from the register. It is valid the same cycle ir_shift is high.
  - The TAP or top level is responsible for negedge retiming; this block does not retime.
- ir_tdo_en = ir_shift (combinational).
- instr = instr_q. The new instruction takes effect the cycle after the ir_update edge (1-cycle latency).
- Decode is combinational from instr_q and is exactly one-hot across {sel_bypass, sel_idcode, sel_bsr}:
  - OP_EXTEST: sel_bsr = 1, extest_mode = 1.
  - OP_SAMPLE: sel_bsr = 1, extest_mode = 0.
  - OP_IDCODE: sel_idcode = 1.
  - OP_BYPASS or any other value: sel_bypass = 1.
- Selects are stable during Capture/Shift-IR. They change only on update, tap_reset or TRST.
- TRST mid-shift: all state is lost immediately; no partial instruction is latched.
- ir_update without a prior shift latches the captured pattern (…01). This decodes to OP_SAMPLE when IR_WIDTH = 4.

Optional Feature:
- Macro: JTAG_IR_CAPTURE_STATUS_EN.
- When defined:
  - Adds input status, width IR_WIDTH-2.
  - Capture-IR loads shift_q ← {status, 2'b01}.
  - Lets the debugger read sticky status through IR scans.
- When undefined:
  - No status port.
  - Upper capture bits are 0.
- Decode and update behaviour are identical in both builds.

Test Plan:
- Reset value: assert TRST for 2 cycles, then release → instr = 4'b0010, sel_idcode = 1, sel_bypass = 0, sel_bsr = 0, ir_tdo = 0.
- Capture then shift: ir_capture 1 cycle, then ir_shift 4 cycles with TDI = 1,1,1,1.
  - ir_tdo sampled before each shift edge = 1,0,0,0.
  - ir_update → instr = 4'b1111, sel_bypass = 1.
- EXTEST load: shift TDI = 0,0,0,0, then update → extest_mode = 1, sel_bsr = 1 the cycle after update. Selects are unchanged during the shift cycles.
- Undefined opcode: shift in 4'b0101 (TDI LSB-first 1,0,1,0), then update → instr = 4'b0101, sel_bypass = 1, others 0.
- Reset priority and async reset:
  - tap_reset asserted together with ir_update while shift_q = 4'b0000 → instr = 4'b0010.
  - Separately, TRST pulsed mid-shift between TCK edges → outputs reset immediately, without waiting for a TCK edge.
- Status capture (JTAG_IR_CAPTURE_STATUS_EN defined): status = 2'b10, capture, then shift 4 cycles → ir_tdo sequence = 1,0,0,1.
